// File: rtl/alu_stream_sequencer.sv
// Sequences the shared ALU across a block of words in data memory.
// Each element reads A (and B, in vector mode) through the synchronous read
// port, presents the operands to the ALU with the latched opcode, and
// writes the ALU result to the destination buffer.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   start, op, use_scalar   command strobe (sampled in IDLE), opcode, B source
//   scalar_b                scalar B operand
//   a_base/b_base/dst_base  buffer base addresses (wrap modulo 2^ADDR_WIDTH)
//   length                  element count, 0 allowed
//   busy, done, error       status: busy outside IDLE, done/error pulses
//   mem_rd_*                read port, data returns the cycle after mem_rd_en
//   mem_wr_*                write port; mem_wr_data forwards alu_out
//   alu_control, src_a/b    ALU opcode and registered operands
//   alu_out                 combinational ALU result
module alu_stream_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic                  use_scalar,
  input  logic [WIDTH-1:0]      scalar_b,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]      mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]      mem_wr_data,
  output logic [3:0]            alu_control,
  output logic [WIDTH-1:0]      src_a,
  output logic [WIDTH-1:0]      src_b,
  input  logic [WIDTH-1:0]      alu_out
);

  localparam int unsigned OP_WIDTH = 4;
  localparam logic [OP_WIDTH-1:0] OP_NOP = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_LD_B = 3'd3,
    S_WB   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [LEN_WIDTH-1:0]  idx_q, idx_d, len_q;
  logic [OP_WIDTH-1:0]   op_q, op_n;
  logic                  scalar_mode_q, scalar_mode_n;
  logic [WIDTH-1:0]      scalar_q;
  logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, dst_base_q;
  logic [ADDR_WIDTH-1:0] a_base_n, b_base_n, dst_base_n;
  logic [ADDR_WIDTH-1:0] idx_addr;
  logic                  load_cfg;
  logic                  op_illegal;

  logic                  busy_d, done_d, error_d, rd_en_d, wr_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d, wr_addr_d;
  logic [OP_WIDTH-1:0]   alu_ctrl_d;
  logic [WIDTH-1:0]      src_a_d, src_b_d;

  assign op_illegal = (op >= 4'b1011) && (op <= 4'b1110);

  // The ALU result is only valid while the WB opcode is applied, so the
  // write data is forwarded combinationally and gated by the write strobe.
  assign mem_wr_data = mem_wr_en ? alu_out : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the output values for the state being entered, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    load_cfg      = 1'b0;
    error_d       = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    rd_en_d       = 1'b0;
    rd_addr_d     = '0;
    wr_en_d       = 1'b0;
    wr_addr_d     = '0;
    alu_ctrl_d    = OP_NOP;
    src_a_d       = src_a;
    src_b_d       = src_b;
    op_n          = op_q;
    scalar_mode_n = scalar_mode_q;
    a_base_n      = a_base_q;
    b_base_n      = b_base_q;
    dst_base_n    = dst_base_q;
    idx_addr      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_illegal) begin
            error_d = 1'b1;
          end else if (length == '0) begin
            state_d = S_FIN;
          end else begin
            state_d  = S_RD_A;
            idx_d    = '0;
            load_cfg = 1'b1;
          end
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        src_a_d = mem_rd_data;
        state_d = S_LD_B;
      end
      S_LD_B: begin
        src_b_d = scalar_mode_q ? scalar_q : mem_rd_data;
        state_d = S_WB;
      end
      S_WB: begin
        if (idx_q == len_q - LEN_WIDTH'(1)) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + LEN_WIDTH'(1);
          state_d = S_RD_A;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Entering RD_A from IDLE must use the command inputs being latched now
    if (load_cfg) begin
      op_n          = op;
      scalar_mode_n = use_scalar;
      a_base_n      = a_base;
      b_base_n      = b_base;
      dst_base_n    = dst_base;
    end
    idx_addr = ADDR_WIDTH'(idx_d);
    busy_d   = (state_d != S_IDLE);

    case (state_d)
      S_RD_A: begin
        rd_en_d   = 1'b1;
        rd_addr_d = a_base_n + idx_addr;
      end
      S_RD_B: begin
        if (!scalar_mode_n) begin
          rd_en_d   = 1'b1;
          rd_addr_d = b_base_n + idx_addr;
        end
      end
      S_WB: begin
        alu_ctrl_d = op_n;
        wr_en_d    = 1'b1;
        wr_addr_d  = dst_base_n + idx_addr;
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

  // Latched command, element index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      len_q         <= '0;
      op_q          <= OP_NOP;
      scalar_mode_q <= 1'b0;
      scalar_q      <= '0;
      a_base_q      <= '0;
      b_base_q      <= '0;
      dst_base_q    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      alu_control   <= OP_NOP;
      src_a         <= '0;
      src_b         <= '0;
    end else begin
      if (load_cfg) begin
        len_q         <= length;
        op_q          <= op;
        scalar_mode_q <= use_scalar;
        scalar_q      <= scalar_b;
        a_base_q      <= a_base;
        b_base_q      <= b_base;
        dst_base_q    <= dst_base;
      end
      idx_q       <= idx_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      mem_rd_en   <= rd_en_d;
      mem_rd_addr <= rd_addr_d;
      mem_wr_en   <= wr_en_d;
      mem_wr_addr <= wr_addr_d;
      alu_control <= alu_ctrl_d;
      src_a       <= src_a_d;
      src_b       <= src_b_d;
    end
  end

endmodule
